zbus_mem_req: RTL



---
 rtl/zbus_mem_req.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/zbus_mem_req.sv
// zbus_mem_req: Z80-side bus responder. Watches Z80 strobes on zneg, raises one
// arbiter request per memory cycle, stalls the Z80 clock generator until the
// transfer is done, and drives read data back onto the Z80 bus.
module zbus_mem_req #(
   parameter int unsigned RD_LAT = 2,
   parameter int unsigned ADDR_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              zpos,
   input  logic              zneg,
   input  logic [1:0]        turbo,
   input  logic              m1_n,
   input  logic              mreq_n,
   input  logic              iorq_n,
   input  logic              rd_n,
   input  logic              wr_n,
   input  logic              rfsh_n,
   input  logic [ADDR_W-1:0] za,
   input  logic [7:0]        zd_in,
   output logic              cpu_req,
   output logic              cpu_rnw,
   output logic [ADDR_W-1:0] cpu_addr,
   output logic [7:0]        cpu_wrdata,
   input  logic              cpu_ack,
   input  logic [7:0]        cpu_rddata,
   output logic [7:0]        zd_out,
   output logic              zd_oe,
   output logic              cpu_stall,
   output logic              iorq_s
);

   localparam int unsigned CNT_W = 3;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      REQ   = 2'd1,
      WAITD = 2'd2,
      HOLD  = 2'd3
   } state_t;

   state_t            state, state_d;
   logic [CNT_W-1:0]  cnt, cnt_d;
   logic              cyc_seen, cyc_seen_d;
   logic              io_seen, io_seen_d;
   logic              abort, abort_d;
   logic              req_d, rnw_d, stall_d, oe_d, iorq_s_d;
   logic [ADDR_W-1:0] addr_d;
   logic [7:0]        wrdata_d, zd_out_d;
   logic              mem_rd_c, mem_wr_c, io_c;

   // Stall behaviour is the same in every turbo mode and only zneg is a sample
   // point, so turbo and zpos are not needed here.
   logic unused_ok;
   assign unused_ok = ^{zpos, turbo};

   // Bus cycle decode; refresh reads and interrupt acknowledge are excluded.
   assign mem_rd_c = !mreq_n && !rd_n && rfsh_n;
   assign mem_wr_c = !mreq_n && !wr_n;
   assign io_c     = !iorq_n && m1_n;

   // Next-state and next-output logic for the request FSM and the seen flags.
   always_comb begin
      state_d    = state;
      cnt_d      = cnt;
      cyc_seen_d = cyc_seen;
      io_seen_d  = io_seen;
      abort_d    = abort;
      req_d      = cpu_req;
      rnw_d      = cpu_rnw;
      stall_d    = cpu_stall;
      oe_d       = zd_oe;
      iorq_s_d   = 1'b0;
      addr_d     = cpu_addr;
      wrdata_d   = cpu_wrdata;
      zd_out_d   = zd_out;

      if (zneg) begin
         if (iorq_n) begin
            io_seen_d = 1'b0;
         end else if (io_c && !io_seen) begin
            iorq_s_d  = 1'b1;
            io_seen_d = 1'b1;
         end
         if (mreq_n) begin
            cyc_seen_d = 1'b0;
         end else if (mem_rd_c || mem_wr_c) begin
            cyc_seen_d = 1'b1;
         end
      end

      case (state)
         IDLE: begin
            if (zneg && (mem_rd_c || mem_wr_c) && !cyc_seen) begin
               addr_d   = za;
               wrdata_d = zd_in;
               rnw_d    = mem_rd_c;
               req_d    = 1'b1;
               stall_d  = 1'b1;
               state_d  = REQ;
            end
         end
         REQ: begin
            // An ack takes priority over a simultaneous abort.
            if (cpu_ack) begin
               req_d = 1'b0;
               if (cpu_rnw) begin
                  cnt_d   = CNT_W'(RD_LAT);
                  abort_d = mreq_n;
                  state_d = WAITD;
               end else begin
                  stall_d = 1'b0;
                  state_d = IDLE;
               end
            end else if (mreq_n) begin
               req_d   = 1'b0;
               stall_d = 1'b0;
               state_d = IDLE;
            end
         end
         WAITD: begin
            cnt_d = cnt - CNT_W'(1);
            if (mreq_n) begin
               abort_d = 1'b1;
            end
            if (cnt == CNT_W'(1)) begin
               zd_out_d = cpu_rddata;
               stall_d  = 1'b0;
               abort_d  = 1'b0;
               if (mreq_n || abort) begin
                  state_d = IDLE;
               end else begin
                  oe_d    = !rd_n;
                  state_d = HOLD;
               end
            end
         end
         HOLD: begin
            if (mreq_n) begin
               oe_d    = 1'b0;
               state_d = IDLE;
            end else begin
               oe_d = !rd_n;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and output registers; reset clears everything asynchronously.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         cnt        <= '0;
         cyc_seen   <= 1'b0;
         io_seen    <= 1'b0;
         abort      <= 1'b0;
         cpu_req    <= 1'b0;
         cpu_rnw    <= 1'b0;
         cpu_stall  <= 1'b0;
         zd_oe      <= 1'b0;
         iorq_s     <= 1'b0;
         cpu_addr   <= '0;
         cpu_wrdata <= 8'h00;
         zd_out     <= 8'h00;
      end else begin
         state      <= state_d;
         cnt        <= cnt_d;
         cyc_seen   <= cyc_seen_d;
         io_seen    <= io_seen_d;
         abort      <= abort_d;
         cpu_req    <= req_d;
         cpu_rnw    <= rnw_d;
         cpu_stall  <= stall_d;
         zd_oe      <= oe_d;
         iorq_s     <= iorq_s_d;
         cpu_addr   <= addr_d;
         cpu_wrdata <= wrdata_d;
         zd_out     <= zd_out_d;
      end
   end

endmodule
